// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM
// state encoding and access-size decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Access size in bytes from funct3[1:0]; 2'b11 is illegal and caught elsewhere.
  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte-lane mask of an access starting at lane 0.
  function automatic logic [3:0] lane_mask(input logic [2:0] s);
    case (s)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Loads allow B/H/W/BU/HU, stores only B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the load/store unit (master) and the
// data-memory controller (slave).
//
// Request channel: a transfer happens on a rising edge where req_valid and
// req_ready are both high; the request fields are only sampled on that edge.
// Response channel: no backpressure; rsp_valid is a single-cycle pulse, and
// rsp_rdata/rsp_err are meaningful only while rsp_valid is high.
interface dmem_if #(parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// Word-organised storage: DEPTH_WORDS x 32 bits, byte-lane write enables,
// synchronous read.
module dmem_bank #(
  parameter int DEPTH_WORDS = 64,
  parameter     INIT_FILE   = "",
  parameter int BW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [BW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked RV32 data memory: byte-addressed, little-endian, splits
// word-crossing accesses into two word accesses and flags bad accesses.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns any misaligned access
// into an error instead of splitting it.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter     INIT_FILE   = ""
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus,
  output state_t dbg_state
);

  localparam int BW  = $clog2(DEPTH_WORDS);
  localparam int WW  = ADDR_W - 2;
  localparam int CAP = 4 * DEPTH_WORDS;

  state_t        st, st_nx;
  logic          we_q, err_q, cross_q;
  logic [2:0]    f3_q, s_q;
  logic [WW-1:0] w_q;
  logic [1:0]    o_q;
  logic [31:0]   wdata_q, lo_q;

  logic          accept;
  logic [2:0]    s_in;
  logic [31:0]   last_in;
  logic          cross_in, err_in;

  logic [BW-1:0] bank_addr;
  logic [3:0]    bank_be;
  logic [31:0]   bank_wdata, bank_rdata;
  logic [7:0]    be_all;
  logic [63:0]   wd_all, rd_all;
  logic [31:0]   rd_sh, rd_ext;

  assign accept = bus.req_valid && (st == IDLE);

  // Decode the incoming request: size, word-crossing and fault conditions.
  always_comb begin
    s_in     = size_of(bus.req_funct3[1:0]);
    last_in  = 32'(bus.req_addr) + 32'(s_in) - 32'd1;
    cross_in = ({1'b0, bus.req_addr[1:0]} + s_in) > 3'd4;
    err_in   = !f3_legal(bus.req_we, bus.req_funct3) || (last_in >= 32'(CAP));
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((bus.req_addr[1:0] & (s_in[1:0] - 2'd1)) != 2'd0) err_in = 1'b1;
`endif
  end

  // State register, request capture at accept, and low-word capture in ACC2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      f3_q    <= 3'd0;
      s_q     <= 3'd1;
      w_q     <= '0;
      o_q     <= 2'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      st <= st_nx;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= err_in;
        cross_q <= cross_in;
        f3_q    <= bus.req_funct3;
        s_q     <= s_in;
        w_q     <= bus.req_addr[ADDR_W-1:2];
        o_q     <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
      end
      if (st == ACC2) lo_q <= bank_rdata;
    end
  end

  // Store data and lane enables shifted into a two-word window.
  assign be_all = {4'b0000, lane_mask(s_q)} << o_q;
  assign wd_all = {32'd0, wdata_q} << {o_q, 3'b000};

  // Next state and bank port control: word w in ACC1, word w+1 in ACC2.
  always_comb begin
    st_nx      = st;
    bank_addr  = w_q[BW-1:0];
    bank_be    = 4'b0000;
    bank_wdata = wd_all[31:0];
    case (st)
      IDLE: if (accept) st_nx = ACC1;
      ACC1: begin
        if (we_q && !err_q) bank_be = be_all[3:0];
        st_nx = (err_q || !cross_q) ? RESP : ACC2;
      end
      ACC2: begin
        bank_addr  = BW'(w_q + 1'b1);
        bank_wdata = wd_all[63:32];
        if (we_q) bank_be = be_all[7:4];
        st_nx = RESP;
      end
      RESP:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE),
    .BW          (BW)
  ) u_bank (
    .clk   (clk),
    .addr  (bank_addr),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Assemble load bytes (low word held in lo_q when split) and extend.
  always_comb begin
    rd_all = cross_q ? {bank_rdata, lo_q} : {32'd0, bank_rdata};
    rd_sh  = 32'(rd_all >> {o_q, 3'b000});
    case (f3_q)
      F3_B:    rd_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      F3_H:    rd_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      F3_BU:   rd_ext = {24'd0, rd_sh[7:0]};
      F3_HU:   rd_ext = {16'd0, rd_sh[15:0]};
      default: rd_ext = rd_sh;
    endcase
  end

  assign bus.req_ready = (st == IDLE);
  assign bus.rsp_valid = (st == RESP);
  assign bus.rsp_err   = (st == RESP) && err_q;
  assign bus.rsp_rdata = ((st == RESP) && !err_q && !we_q) ? rd_ext : 32'd0;
  assign dbg_state     = st;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: reset values, a table of directed accesses, a
// mid-operation reset sequence, randomized single accesses against a
// byte-array model, and a back-to-back stream with req_valid held high.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int CAP = 256;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  state_t dbg_state;

  dmem_if #(.ADDR_W(8)) bus ();

  dmem_ctrl #(.ADDR_W(8), .DEPTH_WORDS(64), .INIT_FILE("")) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_m [CAP];
  logic [32:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Byte-level reference: applies the access to mem_m and returns the response.
  function automatic void ref_op(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                 input logic [31:0] wdata, output logic err,
                                 output logic [31:0] rdata, output int lat);
    int a, s, o;
    logic legal;
    logic [31:0] v;
    a = int'(addr);
    s = 1 << f3[1:0];
    o = a % 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (a + s - 1 >= CAP);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % s != 0) err = 1'b1;
`endif
    rdata = 32'd0;
    lat = (!err && (o + s > 4)) ? 3 : 2;
    if (err) return;
    if (we) begin
      for (int i = 0; i < s; i++) mem_m[a + i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < s; i++) v[8*i +: 8] = mem_m[a + i];
      case (f3)
        3'd0:    rdata = {{24{v[7]}}, v[7:0]};
        3'd1:    rdata = {{16{v[15]}}, v[15:0]};
        3'd4:    rdata = {24'd0, v[7:0]};
        3'd5:    rdata = {16'd0, v[15:0]};
        default: rdata = v;
      endcase
    end
  endfunction

  function automatic logic [2:0] rand_f3();
    case ($urandom_range(0, 7))
      0, 1:    return 3'd2;
      2:       return 3'd0;
      3:       return 3'd1;
      4:       return 3'd4;
      5:       return 3'd5;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic rand_fields();
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = rand_f3();
    bus.req_addr   = 8'($urandom_range(0, 255));
    bus.req_wdata  = $urandom();
  endtask

  // Issue one request (called just after a negedge) and watch five cycles.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wdata, output logic [31:0] g_rdata,
                        output logic g_err, output int g_lat, output int pulses);
    int n;
    g_rdata = 32'd0;
    g_err   = 1'b0;
    g_lat   = 0;
    pulses  = 0;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rand_fields();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        pulses++;
        if (pulses == 1) begin
          g_rdata = bus.rsp_rdata;
          g_err   = bus.rsp_err;
          g_lat   = i;
        end
      end
    end
  endtask

  task automatic run_chk(input string name, input logic we, input logic [2:0] f3,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] e_rdata, input logic e_err, input int e_lat);
    logic [31:0] rd;
    logic er;
    int lat, pl;
    do_req(we, f3, addr, wdata, rd, er, lat, pl);
    chk({name, "_rdata"}, rd, e_rdata);
    chk({name, "_err"}, 32'(er), 32'(e_err));
    chk({name, "_latency"}, 32'(lat), 32'(e_lat));
    chk({name, "_pulses"}, 32'(pl), 32'd1);
  endtask

  function automatic void add(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                              input logic [31:0] wdata, input logic [31:0] e_rdata,
                              input logic e_err, input int e_lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = e_rdata; v.exp_err = e_err; v.exp_lat = e_lat;
    vt.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        m_err;
    logic [31:0] m_rd, wd;
    int          m_lat, pl, acc_n, rsp_n;
    logic [32:0] e;

    // Directed vectors.
    add(1, F3_W,  8'h04, 32'hCAFEF00D, 32'h0, 0, 2);
    add(1, F3_W,  8'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    add(1, F3_W,  8'h0C, 32'hAABBCCDD, 32'h0, 0, 2);
    add(0, F3_W,  8'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    add(0, F3_B,  8'h13, 32'h0, 32'hFFFFFFDE, 0, 2);
    add(0, F3_BU, 8'h13, 32'h0, 32'h000000DE, 0, 2);
    add(0, F3_HU, 8'h12, 32'h0, 32'h0000DEAD, 0, 2);
    add(0, F3_H,  8'h10, 32'h0, 32'hFFFFBEEF, 0, 2);
    add(0, F3_B,  8'h11, 32'h0, 32'hFFFFFFBE, 0, 2);
    add(1, F3_H,  8'h06, 32'h00008001, 32'h0, 0, 2);
    add(0, F3_H,  8'h06, 32'h0, 32'hFFFF8001, 0, 2);
    add(0, F3_HU, 8'h06, 32'h0, 32'h00008001, 0, 2);
    add(0, F3_W,  8'h04, 32'h0, 32'h8001F00D, 0, 2);
`ifndef DMEM_MISALIGN_TRAP_EN
    add(1, F3_W,  8'h0E, 32'h11223344, 32'h0, 0, 3);
    add(0, F3_W,  8'h0E, 32'h0, 32'h11223344, 0, 3);
    add(0, F3_W,  8'h0C, 32'h0, 32'h3344CCDD, 0, 2);
    add(0, F3_W,  8'h10, 32'h0, 32'hDEAD1122, 0, 2);
    add(0, F3_HU, 8'h0F, 32'h0, 32'h00002233, 0, 3);
    add(0, F3_H,  8'h0F, 32'h0, 32'h00002233, 0, 3);
    add(0, F3_B,  8'h0F, 32'h0, 32'h00000033, 0, 2);
    add(0, F3_HU, 8'h05, 32'h0, 32'h000001F0, 0, 2);
    add(1, F3_B,  8'h10, 32'hFFFFFF77, 32'h0, 0, 2);
    add(0, F3_W,  8'h10, 32'h0, 32'hDEAD1177, 0, 2);
`else
    add(1, F3_W,  8'h0E, 32'h11223344, 32'h0, 1, 2);
    add(0, F3_W,  8'h0E, 32'h0, 32'h0, 1, 2);
    add(0, F3_W,  8'h0C, 32'h0, 32'hAABBCCDD, 0, 2);
    add(0, F3_W,  8'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    add(0, F3_HU, 8'h0F, 32'h0, 32'h0, 1, 2);
    add(0, F3_H,  8'h05, 32'h0, 32'h0, 1, 2);
    add(1, F3_H,  8'h11, 32'h0000FFFF, 32'h0, 1, 2);
    add(1, F3_B,  8'h10, 32'hFFFFFF77, 32'h0, 0, 2);
    add(0, F3_W,  8'h10, 32'h0, 32'hDEADBE77, 0, 2);
`endif
    add(0, F3_W,  8'hFE, 32'h0, 32'h0, 1, 2);
    add(0, F3_H,  8'hFF, 32'h0, 32'h0, 1, 2);
    add(0, 3'b011, 8'h10, 32'h0, 32'h0, 1, 2);
    add(0, 3'b110, 8'h10, 32'h0, 32'h0, 1, 2);
    add(1, 3'b100, 8'h10, 32'hFFFFFFFF, 32'h0, 1, 2);
    add(1, 3'b011, 8'h10, 32'hFFFFFFFF, 32'h0, 1, 2);
`ifndef DMEM_MISALIGN_TRAP_EN
    add(0, F3_W,  8'h10, 32'h0, 32'hDEAD1177, 0, 2);
`else
    add(0, F3_W,  8'h10, 32'h0, 32'hDEADBE77, 0, 2);
`endif

    // Reset and reset values.
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 8'd0;
    bus.req_wdata = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill every word so the model and the memory start identical.
    for (int i = 0; i < 64; i++) begin
      wd = $urandom();
      ref_op(1'b1, F3_W, 8'(4 * i), wd, m_err, m_rd, m_lat);
      run_chk($sformatf("fill_%0d", i), 1'b1, F3_W, 8'(4 * i), wd, m_rd, m_err, m_lat);
    end

    // Table-driven directed vectors; the model follows along.
    for (int i = 0; i < vt.size(); i++) begin
      ref_op(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, m_err, m_rd, m_lat);
      run_chk($sformatf("vec_%0d", i), vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata,
              vt[i].exp_rdata, vt[i].exp_err, vt[i].exp_lat);
    end

    // Reset in the middle of a store.
    bus.req_we = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_wdata = 32'hA5A5A5A5;
`ifndef DMEM_MISALIGN_TRAP_EN
    bus.req_addr = 8'h1E;
`else
    bus.req_addr = 8'h1C;
`endif
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq_acc1_state", 32'(dbg_state), 32'(ACC1));
`ifndef DMEM_MISALIGN_TRAP_EN
    @(negedge clk);
    chk("rst_seq_acc2_state", 32'(dbg_state), 32'(ACC2));
    mem_m[8'h1E] = 8'hA5;
    mem_m[8'h1F] = 8'hA5;
`endif
    chk("rst_seq_no_rsp_before", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_seq_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("rst_seq_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pl = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) pl++;
      @(negedge clk);
    end
    chk("rst_seq_no_rsp_after", 32'(pl), 32'd0);
    chk("rst_seq_ready_after", 32'(bus.req_ready), 32'd1);
    ref_op(1'b0, F3_W, 8'h1C, 32'd0, m_err, m_rd, m_lat);
    run_chk("rst_seq_word_w", 1'b0, F3_W, 8'h1C, 32'd0, m_rd, m_err, m_lat);
    ref_op(1'b0, F3_W, 8'h20, 32'd0, m_err, m_rd, m_lat);
    run_chk("rst_seq_word_w1", 1'b0, F3_W, 8'h20, 32'd0, m_rd, m_err, m_lat);

    // Randomized single accesses against the model.
    for (int i = 0; i < 150; i++) begin
      logic we_r;
      logic [2:0] f3_r;
      logic [7:0] a_r;
      we_r = 1'($urandom_range(0, 1));
      f3_r = rand_f3();
      a_r  = 8'($urandom_range(0, 255));
      wd   = $urandom();
      ref_op(we_r, f3_r, a_r, wd, m_err, m_rd, m_lat);
      run_chk($sformatf("rand_%0d", i), we_r, f3_r, a_r, wd, m_rd, m_err, m_lat);
    end

    // Back-to-back stream with req_valid held high.
    acc_n = 0;
    rsp_n = 0;
    rand_fields();
    bus.req_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (bus.rsp_valid) begin
        rsp_n++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra_rsp: got a response, want none pending");
        end else begin
          e = exp_q.pop_front();
          chk("stream_rdata", bus.rsp_rdata, e[31:0]);
          chk("stream_err", 32'(bus.rsp_err), 32'(e[32]));
        end
      end
      if (bus.req_ready) begin
        ref_op(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata, m_err, m_rd, m_lat);
        exp_q.push_back({m_err, m_rd});
        acc_n++;
      end
      @(posedge clk);
      #1;
      rand_fields();
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    for (int d = 0; d < 5; d++) begin
      if (bus.rsp_valid) begin
        rsp_n++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("drain_rdata", bus.rsp_rdata, e[31:0]);
          chk("drain_err", 32'(bus.rsp_err), 32'(e[32]));
        end
      end
      @(negedge clk);
    end
    chk("stream_pending", 32'(exp_q.size()), 32'd0);
    chk("stream_rsp_count", 32'(rsp_n), 32'(acc_n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
